// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: command, operand-stream, accumulator and result signals
// shared by the sequencer and its environment.
// Optional feature macro: ADDER_SEQ_BIAS_EN adds the 'bias' command operand.
interface adder_seq_ctrl_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned LEN_W    = 11
);
    logic                start;
    logic [LEN_W-1:0]    len;
    logic                busy;
    logic                in_valid;
    logic [BITWIDTH-1:0] in_data;
    logic                in_ready;
    logic                acc_en;
    logic                acc_clear;
    logic [BITWIDTH-1:0] acc_data;
    logic [BITWIDTH-1:0] acc_sum;
    logic                out_valid;
    logic [BITWIDTH-1:0] out_data;
    logic                out_ready;
    logic                done;
`ifdef ADDER_SEQ_BIAS_EN
    logic [BITWIDTH-1:0] bias;
`endif

    // Sequencer side.
    modport slave (
`ifdef ADDER_SEQ_BIAS_EN
        input  bias,
`endif
        input  start, len, in_valid, in_data, acc_sum, out_ready,
        output busy, in_ready, acc_en, acc_clear, acc_data, out_valid, out_data, done
    );

    // Environment side: command source, operand stream, accumulator, result sink.
    modport master (
`ifdef ADDER_SEQ_BIAS_EN
        output bias,
`endif
        output start, len, in_valid, in_data, acc_sum, out_ready,
        input  busy, in_ready, acc_en, acc_clear, acc_data, out_valid, out_data, done
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequences one vector reduction on the FP accumulator.
// Clears the accumulator, streams exactly len operands into it, then holds
// the sum on a valid/ready result port until it is taken.
// Optional feature macro: ADDER_SEQ_BIAS_EN inserts a BIAS cycle after CLEAR
// that adds the latched bias operand before the stream.
module adder_seq_ctrl #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned MAX_LEN  = 1024,
    parameter int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
    input logic             clk,
    input logic             rst,
    adder_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
`ifdef ADDER_SEQ_BIAS_EN
        StBias,
`endif
        StAccum,
        StOut
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_sat;
`ifdef ADDER_SEQ_BIAS_EN
    logic [BITWIDTH-1:0] bias_q;
`endif

    assign cnt_inc = cnt_q + LEN_W'(1);
    assign len_sat = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

    // Control FSM: state, operand counter and latched command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef ADDER_SEQ_BIAS_EN
            bias_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        len_q   <= len_sat;
`ifdef ADDER_SEQ_BIAS_EN
                        bias_q  <= bus.bias;
`endif
                    end
                end
                StClear: begin
`ifdef ADDER_SEQ_BIAS_EN
                    state_q <= StBias;
`else
                    state_q <= (len_q == '0) ? StOut : StAccum;
`endif
                end
`ifdef ADDER_SEQ_BIAS_EN
                StBias: begin
                    state_q <= (len_q == '0) ? StOut : StAccum;
                end
`endif
                StAccum: begin
                    // Leave on equality so the counter never wraps.
                    if (bus.in_valid) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_q <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode from state; acc_sum is stable in OUT since acc_en is low.
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.in_ready  = (state_q == StAccum);
        bus.acc_clear = (state_q == StClear);
        bus.acc_en    = (state_q == StAccum) && bus.in_valid;
        bus.acc_data  = '0;
        if (state_q == StAccum) begin
            bus.acc_data = bus.in_data;
        end
`ifdef ADDER_SEQ_BIAS_EN
        if (state_q == StBias) begin
            bus.acc_en   = 1'b1;
            bus.acc_data = bias_q;
        end
`endif
        bus.out_valid = (state_q == StOut);
        bus.out_data  = bus.acc_sum;
        bus.done      = (state_q == StOut) && bus.out_ready;
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized bench for adder_seq_ctrl with a behavioural
// accumulator and a sum/latency reference model.
// Optional feature macro: ADDER_SEQ_BIAS_EN enables the bias scenario.
module tb_adder_seq_ctrl;
    localparam int unsigned BITWIDTH = 32;
    localparam int unsigned MAX_LEN  = 1024;
    localparam int unsigned LEN_W    = 11;
`ifdef ADDER_SEQ_BIAS_EN
    localparam int BIAS_CYC = 1;
`else
    localparam int BIAS_CYC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    adder_seq_ctrl_if #(.BITWIDTH(BITWIDTH), .LEN_W(LEN_W)) bus ();

    adder_seq_ctrl #(.BITWIDTH(BITWIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Non-negative multiples of 0.5 below 2^23 are exact in single precision.
    function automatic logic [31:0] fp_of_halves(input int unsigned h);
        int p;
        logic [31:0] m;
        if (h == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 32; i++) if (h[i]) p = i;
        m = h << (23 - p);
        return {1'b0, 8'(p + 126), m[22:0]};
    endfunction

    function automatic int unsigned halves_of(input logic [31:0] f);
        int e;
        int unsigned m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]);
        m = {8'h0, 1'b1, f[22:0]};
        if (e <= 149) return m >> (149 - e);
        return m << (e - 149);
    endfunction

    // Accumulator model: registered sum with clear/enable, no reset.
    int unsigned acc_h = 0;
    always @(posedge clk) begin
        if (bus.acc_clear) acc_h <= 0;
        else if (bus.acc_en) acc_h <= acc_h + halves_of(bus.acc_data);
    end
    assign bus.acc_sum = fp_of_halves(acc_h);

    logic [31:0] ops[$];
    int unsigned bias_h = 0;

    function automatic logic [31:0] expect_sum(input int eff);
        int unsigned h;
        h = bias_h;
        for (int i = 0; i < eff; i++) h += halves_of(ops[i]);
        return fp_of_halves(h);
    endfunction

    // Observations of the last command.
    logic [31:0] r_result;
    int r_first_ov, r_ov_windows, r_en_cnt, r_clear_cnt, r_overlap, r_unstable;
    int r_done_cnt, r_done_bad, r_gaps, r_accepted;
    bit r_timeout;

    // Issue one command and run it to the result handshake. Window w is the
    // cycle after the w-th edge following the accepted start.
    task automatic drive_cmd(input int n, input int gap_mode, input int hold,
                             input bit flood, input bit poke);
        int idx;
        int budget;
        bit fin;
        idx = 0; fin = 0; budget = 3 * n + 64;
        r_result = 32'hDEAD_BEEF; r_first_ov = 0; r_ov_windows = 0; r_en_cnt = 0;
        r_clear_cnt = 0; r_overlap = 0; r_unstable = 0; r_done_cnt = 0; r_done_bad = 0;
        r_gaps = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.len = LEN_W'(n); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int w = 1; w <= budget && !fin; w++) begin
            @(negedge clk);
            bus.start = poke && ($urandom_range(0, 1) == 1);
            bus.len = poke ? LEN_W'($urandom_range(1, 3)) : LEN_W'(n);
            case (gap_mode)
                1: bus.in_valid = (w % 2) == 0;
                2: bus.in_valid = $urandom_range(0, 99) >= 30;
                default: bus.in_valid = 1'b1;
            endcase
            if (!flood && idx >= ops.size()) bus.in_valid = 1'b0;
            bus.in_data = (idx < ops.size()) ? ops[idx] : 32'h3F80_0000;
            bus.out_ready = r_ov_windows >= hold;
            #1;
            if (bus.acc_clear) r_clear_cnt++;
            if (bus.acc_en) r_en_cnt++;
            if (bus.acc_en && bus.acc_clear) r_overlap++;
            if (bus.in_ready && !bus.in_valid) r_gaps++;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid) begin
                if (r_ov_windows == 0) begin
                    r_first_ov = w;
                    r_result = bus.out_data;
                end else if (bus.out_data !== r_result) begin
                    r_unstable++;
                end
                r_ov_windows++;
            end
            if (bus.done) begin
                if (bus.out_valid && bus.out_ready) r_done_cnt++;
                else r_done_bad++;
            end
            if (bus.out_valid && bus.out_ready) fin = 1;
        end
        r_accepted = idx;
        r_timeout = !fin;
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.len = LEN_W'(3); bus.in_valid = 1'b1; bus.in_data = 32'h3F80_0000;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.acc_en !== 1'b0) begin failures++; $display("FAIL reset_acc_en got=%b exp=0", bus.acc_en); end
        checks++; if (bus.acc_clear !== 1'b0) begin failures++; $display("FAIL reset_acc_clear got=%b exp=0", bus.acc_clear); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.acc_data !== 32'h0) begin failures++; $display("FAIL reset_acc_data got=%h exp=0", bus.acc_data); end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_basic();
        ops = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        drive_cmd(4, 0, 0, 0, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (r_result !== 32'h4120_0000) begin failures++; $display("FAIL basic_sum got=%h exp=41200000", r_result); end
        checks++; if (r_first_ov !== 6 + BIAS_CYC) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", r_first_ov, 6 + BIAS_CYC); end
        checks++; if (r_done_cnt !== 1 || r_done_bad !== 0) begin failures++; $display("FAIL basic_done got=%0d/%0d exp=1/0", r_done_cnt, r_done_bad); end
        checks++; if (r_clear_cnt !== 1 || r_overlap !== 0) begin failures++; $display("FAIL basic_clear got=%0d/%0d exp=1/0", r_clear_cnt, r_overlap); end
        checks++; if (r_accepted !== 4) begin failures++; $display("FAIL basic_accepts got=%0d exp=4", r_accepted); end
    endtask

    task automatic test_gaps();
        ops = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        drive_cmd(4, 1, 5, 0, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL gaps_timeout got=1 exp=0"); end
        checks++; if (r_result !== 32'h4120_0000) begin failures++; $display("FAIL gaps_sum got=%h exp=41200000", r_result); end
        checks++; if (r_unstable !== 0) begin failures++; $display("FAIL gaps_stable got=%0d exp=0", r_unstable); end
        checks++; if (r_ov_windows !== 6) begin failures++; $display("FAIL gaps_hold got=%0d exp=6", r_ov_windows); end
        checks++; if (r_en_cnt !== 4 + BIAS_CYC) begin failures++; $display("FAIL gaps_en_pulses got=%0d exp=%0d", r_en_cnt, 4 + BIAS_CYC); end
        checks++; if (r_first_ov !== 6 + BIAS_CYC + r_gaps) begin failures++; $display("FAIL gaps_latency got=%0d exp=%0d", r_first_ov, 6 + BIAS_CYC + r_gaps); end
        checks++; if (r_done_cnt !== 1 || r_done_bad !== 0) begin failures++; $display("FAIL gaps_done got=%0d/%0d exp=1/0", r_done_cnt, r_done_bad); end
    endtask

    task automatic test_len_zero();
        ops = {};
        drive_cmd(0, 0, 0, 1, 0);
        checks++; if (r_timeout) begin failures++; $display("FAIL zero_timeout got=1 exp=0"); end
        checks++; if (r_clear_cnt !== 1) begin failures++; $display("FAIL zero_clear got=%0d exp=1", r_clear_cnt); end
        checks++; if (r_accepted !== 0) begin failures++; $display("FAIL zero_accepts got=%0d exp=0", r_accepted); end
        checks++; if (r_result !== 32'h0) begin failures++; $display("FAIL zero_sum got=%h exp=00000000", r_result); end
        checks++; if (r_first_ov !== 2 + BIAS_CYC) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", r_first_ov, 2 + BIAS_CYC); end
        checks++; if (r_en_cnt !== BIAS_CYC) begin failures++; $display("FAIL zero_en_pulses got=%0d exp=%0d", r_en_cnt, BIAS_CYC); end
    endtask

    task automatic test_reset_mid();
        int got;
        got = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.len = LEN_W'(8); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int w = 0; w < 20 && got < 2; w++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h4040_0000;
            #1;
            if (bus.in_valid && bus.in_ready) got++;
        end
        checks++; if (got !== 2) begin failures++; $display("FAIL mid_accepts got=%0d exp=2", got); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({bus.busy, bus.in_ready, bus.acc_en, bus.acc_clear, bus.out_valid, bus.done} !== 6'b0)
            begin failures++; $display("FAIL mid_outputs got=%b exp=000000",
                {bus.busy, bus.in_ready, bus.acc_en, bus.acc_clear, bus.out_valid, bus.done}); end
        checks++; if (bus.acc_data !== 32'h0) begin failures++; $display("FAIL mid_acc_data got=%h exp=0", bus.acc_data); end
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        ops = {32'h40A0_0000};
        drive_cmd(1, 0, 0, 0, 0);
        checks++; if (r_result !== 32'h40A0_0000) begin failures++; $display("FAIL mid_restart_sum got=%h exp=40a00000", r_result); end
        checks++; if (r_accepted !== 1 || r_timeout) begin failures++; $display("FAIL mid_restart_accepts got=%0d exp=1", r_accepted); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        ops = {};
        for (int i = 0; i < 6; i++) ops.push_back(fp_of_halves(2 * $urandom_range(0, 255)));
        exp = expect_sum(6);
        drive_cmd(6, 1, 3, 0, 1);
        checks++; if (r_clear_cnt !== 1) begin failures++; $display("FAIL ign_clear got=%0d exp=1", r_clear_cnt); end
        checks++; if (r_accepted !== 6 || r_timeout) begin failures++; $display("FAIL ign_accepts got=%0d exp=6", r_accepted); end
        checks++; if (r_result !== exp) begin failures++; $display("FAIL ign_sum got=%h exp=%h", r_result, exp); end
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_not_queued got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int k = 0; k < 2; k++) begin
            ops = {};
            for (int i = 0; i < 3 - k; i++) ops.push_back(fp_of_halves(2 * $urandom_range(0, 255)));
            exp = expect_sum(3 - k);
            drive_cmd(3 - k, 0, 0, 0, 0);
            checks++; if (r_result !== exp) begin failures++; $display("FAIL b2b_sum%0d got=%h exp=%h", k, r_result, exp); end
            checks++; if (r_first_ov !== 5 - k + BIAS_CYC) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", k, r_first_ov, 5 - k + BIAS_CYC); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int n;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 20);
            ops = {};
            for (int i = 0; i < n; i++) ops.push_back(fp_of_halves($urandom_range(0, 511)));
            exp = expect_sum(n);
            drive_cmd(n, 2, $urandom_range(0, 3), 0, 0);
            checks++; if (r_result !== exp || r_timeout) begin failures++; $display("FAIL rand_sum%0d got=%h exp=%h", k, r_result, exp); end
            checks++; if (r_accepted !== n) begin failures++; $display("FAIL rand_accepts%0d got=%0d exp=%0d", k, r_accepted, n); end
            checks++; if (r_first_ov !== 2 + BIAS_CYC + n + r_gaps) begin failures++; $display("FAIL rand_latency%0d got=%0d exp=%0d", k, r_first_ov, 2 + BIAS_CYC + n + r_gaps); end
            checks++; if (r_done_cnt !== 1 || r_done_bad !== 0 || r_unstable !== 0) begin failures++; $display("FAIL rand_done%0d got=%0d/%0d/%0d exp=1/0/0", k, r_done_cnt, r_done_bad, r_unstable); end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] exp;
        ops = {};
        for (int i = 0; i < 1100; i++) ops.push_back(fp_of_halves(2 * $urandom_range(0, 255)));
        exp = expect_sum(MAX_LEN);
        drive_cmd(2000, 0, 0, 1, 0);
        checks++; if (r_accepted !== MAX_LEN || r_timeout) begin failures++; $display("FAIL sat_accepts got=%0d exp=%0d", r_accepted, MAX_LEN); end
        checks++; if (r_result !== exp) begin failures++; $display("FAIL sat_sum got=%h exp=%h", r_result, exp); end
        checks++; if (r_first_ov !== 2 + BIAS_CYC + MAX_LEN) begin failures++; $display("FAIL sat_latency got=%0d exp=%0d", r_first_ov, 2 + BIAS_CYC + MAX_LEN); end
    endtask

`ifdef ADDER_SEQ_BIAS_EN
    task automatic test_bias();
        bias_h = 1;
        bus.bias = 32'h3F00_0000;
        ops = {32'h3F80_0000, 32'h3F80_0000};
        drive_cmd(2, 0, 0, 0, 0);
        checks++; if (r_result !== 32'h4020_0000) begin failures++; $display("FAIL bias_sum got=%h exp=40200000", r_result); end
        checks++; if (r_first_ov !== 5) begin failures++; $display("FAIL bias_latency got=%0d exp=5", r_first_ov); end
        ops = {};
        drive_cmd(0, 0, 0, 1, 0);
        checks++; if (r_result !== 32'h3F00_0000) begin failures++; $display("FAIL bias_zero_sum got=%h exp=3f000000", r_result); end
        bias_h = 0;
        bus.bias = 32'h0;
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef ADDER_SEQ_BIAS_EN
        bus.bias = '0;
`endif
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_saturate();
`ifdef ADDER_SEQ_BIAS_EN
        test_bias();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
